// File: rtl/fwd_pkg.sv
// fwd_pkg
// Shared definitions for the operand forwarding / load-use interlock block.
//   SEL_RF, SEL_EXMEM, SEL_MEMWB : operand mux select codes (mux31x16 arg1/arg2/arg3)
//   REG_BITS_DEF                 : default register index width (16 registers)
package fwd_pkg;

    localparam int REG_BITS_DEF = 4;

    localparam logic [1:0] SEL_RF    = 2'b00;
    localparam logic [1:0] SEL_EXMEM = 2'b01;
    localparam logic [1:0] SEL_MEMWB = 2'b10;

endpackage

// File: rtl/fwd_cmp.sv
// fwd_cmp
// Combinational priority compare for one source operand of the ID instruction.
// Ports:
//   rs       in  : source register index
//   use_op   in  : the instruction actually reads this operand
//   ex_rd    in  : destination register tracked in EX
//   ex_we    in  : EX instruction writes ex_rd
//   mem_rd   in  : destination register tracked in MEM
//   mem_we   in  : MEM instruction writes mem_rd
//   sel      out : mux select code (EX beats MEM, otherwise register file)
//   ex_match out : this operand depends on the EX instruction's result
module fwd_cmp
    import fwd_pkg::*;
#(
    parameter int REG_BITS = REG_BITS_DEF
) (
    input  logic [REG_BITS-1:0] rs,
    input  logic                use_op,
    input  logic [REG_BITS-1:0] ex_rd,
    input  logic                ex_we,
    input  logic [REG_BITS-1:0] mem_rd,
    input  logic                mem_we,
    output logic [1:0]          sel,
    output logic                ex_match
);

    logic live;
    logic ex_hit;
    logic mem_hit;

    // r0 is hard-wired zero, so it never needs a forwarded value.
    assign live    = use_op & (rs != '0);
    assign ex_hit  = live & ex_we  & (rs == ex_rd);
    assign mem_hit = live & mem_we & (rs == mem_rd);

    // rs != 0 already guarantees ex_rd != 0 when the indices are equal.
    assign ex_match = ex_hit;

    always_comb begin
        sel = SEL_RF;
        if (ex_hit) begin
            sel = SEL_EXMEM;   // newest value wins over MEM
        end else if (mem_hit) begin
            sel = SEL_MEMWB;
        end
    end

endmodule

// File: rtl/fwd_unit.sv
// fwd_unit
// Operand forwarding and load-use interlock controller for the 16-bit pipeline.
// Tracks EX/MEM destination registers, registers the operand mux selects for
// the EX cycle, and raises a combinational one-cycle stall on load-use hazards.
// Ports:
//   clk, rst            : clock, asynchronous active-high reset
//   hold                : global pipeline freeze, no state advances
//   id_valid            : ID holds a real instruction
//   id_rs_a / id_rs_b   : ID source register indices
//   id_use_a / id_use_b : ID instruction reads the operand
//   id_rd, id_we        : ID destination register and write enable
//   id_load             : ID instruction is a load
//   sel_a, sel_b        : registered operand mux selects (valid in EX)
//   stall               : combinational load-use stall
//   stall_count         : saturating count of stall cycles
module fwd_unit
    import fwd_pkg::*;
#(
    parameter int REG_BITS = REG_BITS_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                hold,
    input  logic                id_valid,
    input  logic [REG_BITS-1:0] id_rs_a,
    input  logic [REG_BITS-1:0] id_rs_b,
    input  logic                id_use_a,
    input  logic                id_use_b,
    input  logic [REG_BITS-1:0] id_rd,
    input  logic                id_we,
    input  logic                id_load,
    output logic [1:0]          sel_a,
    output logic [1:0]          sel_b,
    output logic                stall,
    output logic [15:0]         stall_count
);

    // Tracking state
    logic [REG_BITS-1:0] ex_rd_reg;
    logic                ex_we_reg;
    logic                ex_load_reg;
    logic [REG_BITS-1:0] mem_rd_reg;
    logic                mem_we_reg;
    logic [1:0]          sel_reg [2];
    logic [15:0]         count_reg;
    logic [15:0]         count_next;

    // Per-operand compare (index 0 = A, 1 = B)
    logic [REG_BITS-1:0] rs_arr   [2];
    logic                use_arr  [2];
    logic [1:0]          sel_calc [2];
    logic [1:0]          ex_match;

    assign rs_arr[0]  = id_rs_a;
    assign rs_arr[1]  = id_rs_b;
    assign use_arr[0] = id_use_a;
    assign use_arr[1] = id_use_b;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_cmp
            fwd_cmp #(
                .REG_BITS (REG_BITS)
            ) u_cmp (
                .rs       (rs_arr[gi]),
                .use_op   (use_arr[gi]),
                .ex_rd    (ex_rd_reg),
                .ex_we    (ex_we_reg),
                .mem_rd   (mem_rd_reg),
                .mem_we   (mem_we_reg),
                .sel      (sel_calc[gi]),
                .ex_match (ex_match[gi])
            );
        end
    endgenerate

    // A load in EX has no result yet; a dependent ID instruction must wait one
    // cycle. While frozen nothing moves, so the hazard is masked until release.
    assign stall = id_valid & ex_load_reg & ~hold & (|ex_match);

    assign count_next = (stall && count_reg != 16'hFFFF) ? count_reg + 16'd1 : count_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_rd_reg   <= '0;
            ex_we_reg   <= 1'b0;
            ex_load_reg <= 1'b0;
            mem_rd_reg  <= '0;
            mem_we_reg  <= 1'b0;
            sel_reg[0]  <= SEL_RF;
            sel_reg[1]  <= SEL_RF;
            count_reg   <= '0;
        end else if (!hold) begin
            mem_rd_reg <= ex_rd_reg;
            mem_we_reg <= ex_we_reg;
            count_reg  <= count_next;
            if (stall || !id_valid) begin
                // Bubble into EX; ex_rd is irrelevant once ex_we is cleared.
                ex_we_reg   <= 1'b0;
                ex_load_reg <= 1'b0;
                sel_reg[0]  <= SEL_RF;
                sel_reg[1]  <= SEL_RF;
            end else begin
                ex_rd_reg   <= id_rd;
                ex_we_reg   <= id_we & id_valid;
                ex_load_reg <= id_load;
                sel_reg[0]  <= sel_calc[0];
                sel_reg[1]  <= sel_calc[1];
            end
        end
    end

    assign sel_a       = sel_reg[0];
    assign sel_b       = sel_reg[1];
    assign stall_count = count_reg;

endmodule

// File: tb/tb_fwd_unit.sv
// tb_fwd_unit
// Directed bench for fwd_unit: expected selects/count are queued when each
// instruction is driven into ID and checked once it has moved to EX.
module tb_fwd_unit;

    logic        clk;
    logic        rst;
    logic        hold;
    logic        id_valid;
    logic [3:0]  id_rs_a;
    logic [3:0]  id_rs_b;
    logic        id_use_a;
    logic        id_use_b;
    logic [3:0]  id_rd;
    logic        id_we;
    logic        id_load;
    logic [1:0]  sel_a;
    logic [1:0]  sel_b;
    logic        stall;
    logic [15:0] stall_count;

    int n_checks = 0;
    int n_fails  = 0;

    typedef struct {
        logic [1:0]  ea;
        logic [1:0]  eb;
        logic [15:0] ec;
    } exp_t;

    exp_t sb[$];

    fwd_unit #(.REG_BITS(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .hold        (hold),
        .id_valid    (id_valid),
        .id_rs_a     (id_rs_a),
        .id_rs_b     (id_rs_b),
        .id_use_a    (id_use_a),
        .id_use_b    (id_use_b),
        .id_rd       (id_rd),
        .id_we       (id_we),
        .id_load     (id_load),
        .sel_a       (sel_a),
        .sel_b       (sel_b),
        .stall       (stall),
        .stall_count (stall_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    // Drive one ID cycle, check the combinational stall, then after the edge
    // pop the expected EX-cycle selects and count from the scoreboard.
    task automatic issue(input string tag, input logic v,
                         input logic [3:0] ra, input logic ua,
                         input logic [3:0] rb, input logic ub,
                         input logic [3:0] rd, input logic we, input logic ld,
                         input logic hd, input logic exp_stall,
                         input logic [1:0] ea, input logic [1:0] eb,
                         input logic [15:0] ec);
        exp_t e;
        @(negedge clk);
        id_valid = v;  id_rs_a = ra; id_use_a = ua; id_rs_b = rb; id_use_b = ub;
        id_rd = rd;    id_we = we;   id_load = ld;  hold = hd;
        sb.push_back('{ea: ea, eb: eb, ec: ec});
        #1;
        chk({tag, ".stall"}, {15'd0, stall}, {15'd0, exp_stall});
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk({tag, ".sel_a"}, {14'd0, sel_a}, {14'd0, e.ea});
        chk({tag, ".sel_b"}, {14'd0, sel_b}, {14'd0, e.eb});
        chk({tag, ".count"}, stall_count, e.ec);
        $display("txn %-10s v=%0d rs_a=%0d/%0d rs_b=%0d/%0d rd=%0d we=%0d ld=%0d hold=%0d -> sel_a=%0d sel_b=%0d cnt=%0d",
                 tag, v, ra, ua, rb, ub, rd, we, ld, hd, sel_a, sel_b, stall_count);
    endtask

    initial begin
        rst = 1'b1; hold = 1'b0; id_valid = 1'b0;
        id_rs_a = '0; id_rs_b = '0; id_use_a = 1'b0; id_use_b = 1'b0;
        id_rd = '0; id_we = 1'b0; id_load = 1'b0;
        #12;
        chk("rst.sel_a", {14'd0, sel_a}, 16'd0);
        chk("rst.sel_b", {14'd0, sel_b}, 16'd0);
        chk("rst.stall", {15'd0, stall}, 16'd0);
        chk("rst.count", stall_count, 16'd0);
        @(negedge clk);
        rst = 1'b0;

        //     tag          v  ra ua  rb ub  rd we ld hd st  ea     eb     cnt
        // Back-to-back ALU forwarding
        issue("prod_r3",    1, 0, 0,  0, 0,  3, 1, 0, 0, 0, 2'b00, 2'b00, 0);
        issue("add_r5",     1, 3, 1,  1, 1,  5, 1, 0, 0, 0, 2'b01, 2'b00, 0);
        // Producer, independent op, MEM forward on B
        issue("prod_r4",    1, 0, 0,  0, 0,  4, 1, 0, 0, 0, 2'b00, 2'b00, 0);
        issue("indep",      1, 1, 1,  2, 1,  6, 1, 0, 0, 0, 2'b00, 2'b00, 0);
        issue("cons_r4",    1, 1, 1,  4, 1,  7, 1, 0, 0, 0, 2'b00, 2'b10, 0);
        // Load-use: one stall then MEM forward
        issue("load_r2",    1, 0, 0,  0, 0,  2, 1, 1, 0, 0, 2'b00, 2'b00, 0);
        issue("use_r2_st",  1, 2, 1,  0, 0,  8, 1, 0, 0, 1, 2'b00, 2'b00, 1);
        issue("use_r2",     1, 2, 1,  0, 0,  8, 1, 0, 0, 0, 2'b10, 2'b00, 1);
        // r0 writes are never forwarded, even from a load
        issue("load_r0",    1, 0, 0,  0, 0,  0, 1, 1, 0, 0, 2'b00, 2'b00, 1);
        issue("read_r0",    1, 0, 1,  0, 1, 10, 1, 0, 0, 0, 2'b00, 2'b00, 1);
        // Hazard under hold: frozen, then one stall, then forwarding
        issue("load_r9",    1,10, 1,  0, 0,  9, 1, 1, 0, 0, 2'b01, 2'b00, 1);
        issue("hold1",      1, 9, 0,  9, 1, 12, 1, 0, 1, 0, 2'b01, 2'b00, 1);
        issue("hold2",      1, 9, 0,  9, 1, 12, 1, 0, 1, 0, 2'b01, 2'b00, 1);
        issue("hold3",      1, 9, 0,  9, 1, 12, 1, 0, 1, 0, 2'b01, 2'b00, 1);
        issue("rel_st",     1, 9, 0,  9, 1, 12, 1, 0, 0, 1, 2'b00, 2'b00, 2);
        issue("use_r9",     1, 9, 0,  9, 1, 12, 1, 0, 0, 0, 2'b00, 2'b10, 2);
        issue("load_r11",   1,12, 1,  0, 0, 11, 1, 1, 0, 0, 2'b01, 2'b00, 2);

        // Reset in the middle of a stall clears everything at once
        @(negedge clk);
        id_valid = 1; id_rs_a = 11; id_use_a = 1; id_rs_b = 0; id_use_b = 0;
        id_rd = 13; id_we = 1; id_load = 0; hold = 0;
        #1;
        chk("midrst.pre_stall", {15'd0, stall}, 16'd1);
        #1 rst = 1'b1;
        #1;
        chk("midrst.stall", {15'd0, stall}, 16'd0);
        chk("midrst.sel_a", {14'd0, sel_a}, 16'd0);
        chk("midrst.sel_b", {14'd0, sel_b}, 16'd0);
        chk("midrst.count", stall_count, 16'd0);
        $display("txn midrst     async reset during stall -> stall=%0d sel_a=%0d cnt=%0d", stall, sel_a, stall_count);
        #1 rst = 1'b0;

        issue("no_prod",    1,11, 1, 11, 1, 13, 1, 0, 0, 0, 2'b00, 2'b00, 0);
        // Invalid ID slot becomes a bubble even with a load marked
        issue("invalid",    0,13, 1, 13, 1, 13, 1, 1, 0, 0, 2'b00, 2'b00, 0);
        issue("same_rs",    1,13, 1, 13, 1, 14, 1, 0, 0, 0, 2'b10, 2'b10, 0);
        issue("prod_r14",   1, 0, 0,  0, 0, 14, 1, 0, 0, 0, 2'b00, 2'b00, 0);
        issue("ex_mem_r14", 1,14, 1, 14, 1,  1, 1, 0, 0, 0, 2'b01, 2'b01, 0);

        chk("sb.empty", 16'(sb.size()), 16'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    // Absolute time limit so the bench can never hang.
    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
